// File: rtl/div_seq_param_if.sv
// div_seq_param_if: operand/result bus of the sequential divider.
//
// Handshake semantics (both directions):
//   A transfer happens on a rising clk edge where valid && ready are both 1.
//   The producer holds valid and its payload stable until that edge.
//   The consumer may raise or drop ready freely.
//   Input side: in_valid/dividend/divisor/signed_op are from the producer,
//   and in_ready is from the divider.
//   Output side: out_valid/quotient/remainder/div_by_zero are from the
//   divider, and out_ready is from the consumer.
interface div_seq_param_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             signed_op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;

   // Producer of operands / consumer of results
   modport master (
      output in_valid, dividend, divisor, signed_op, out_ready,
      input  in_ready, out_valid, quotient, remainder, div_by_zero
   );

   // The divider itself
   modport slave (
      input  in_valid, dividend, divisor, signed_op, out_ready,
      output in_ready, out_valid, quotient, remainder, div_by_zero
   );
endinterface

// File: rtl/div_seq_param.sv
// div_seq_param: parametrised restoring divider producing one quotient bit
// per clock. It supports signed and unsigned operation selected at run time,
// and it reports divide-by-zero.
// Optional macro DIV_SEQ_FASTPATH_EN: when |divisor| > |dividend|, the result
// (quotient 0, remainder = dividend) is returned without iterating.
// o_dbg_state encoding: 0 = IDLE, 1 = CALC, 2 = DONE.
module div_seq_param #(
   parameter int WIDTH = 32
) (
   input  logic           clk,
   input  logic           rst,
   div_seq_param_if.slave bus,
   output logic [1:0]     o_dbg_state
);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_next;
   logic [2*WIDTH-1:0] r_work;      // {partial remainder, dividend/quotient}
   logic [WIDTH-1:0]   r_div_mag;
   logic [CW-1:0]      r_cnt;
   logic               r_q_neg;
   logic               r_r_neg;
   logic [WIDTH-1:0]   r_quot;
   logic [WIDTH-1:0]   r_rem;
   logic               r_dbz;
   logic               r_out_valid;

   logic               w_accept;
   logic               w_a_neg;
   logic               w_b_neg;
   logic [WIDTH-1:0]   w_a_mag;
   logic [WIDTH-1:0]   w_b_mag;
   logic               w_b_zero;
   logic               w_fast;
   logic [WIDTH:0]     w_top;
   logic [WIDTH:0]     w_sub;
   logic               w_ge;
   logic [2*WIDTH-1:0] w_step;
   logic [WIDTH-1:0]   w_q_fix;
   logic [WIDTH-1:0]   w_r_fix;
   logic               w_last;

   assign w_accept = bus.in_valid && bus.in_ready;
   assign w_a_neg  = bus.signed_op && bus.dividend[WIDTH-1];
   assign w_b_neg  = bus.signed_op && bus.divisor[WIDTH-1];
   // MIN negates to itself; read as unsigned it is 2^(WIDTH-1), which is what we want
   assign w_a_mag  = w_a_neg ? (~bus.dividend + 1'b1) : bus.dividend;
   assign w_b_mag  = w_b_neg ? (~bus.divisor + 1'b1) : bus.divisor;
   assign w_b_zero = (bus.divisor == '0);

`ifdef DIV_SEQ_FASTPATH_EN
   assign w_fast = !w_b_zero && (w_b_mag > w_a_mag);
`else
   assign w_fast = 1'b0;
`endif

   // One restoring step. The shifted partial remainder needs WIDTH+1 bits,
   // because it can reach 2*|divisor|-1. Bit WIDTH of the difference is 1
   // exactly when the trial subtraction would go negative.
   assign w_top  = r_work[2*WIDTH-1:WIDTH-1];
   assign w_sub  = w_top - {1'b0, r_div_mag};
   assign w_ge   = ~w_sub[WIDTH];
   assign w_step = {(w_ge ? w_sub[WIDTH-1:0] : w_top[WIDTH-1:0]),
                    r_work[WIDTH-2:0], w_ge};

   // The last step and the sign fix-up share one edge.
   assign w_q_fix = r_q_neg ? (~w_step[WIDTH-1:0] + 1'b1) : w_step[WIDTH-1:0];
   assign w_r_fix = r_r_neg ? (~w_step[2*WIDTH-1:WIDTH] + 1'b1)
                            : w_step[2*WIDTH-1:WIDTH];
   assign w_last  = (r_cnt == CW'(WIDTH - 1));

   assign bus.in_ready    = (r_state == IDLE) && !rst;
   assign bus.out_valid   = r_out_valid;
   assign bus.quotient    = r_quot;
   assign bus.remainder   = r_rem;
   assign bus.div_by_zero = r_dbz;
   assign o_dbg_state     = r_state;

   // State register
   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   // Next-state selection
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_next = (w_b_zero || w_fast) ? DONE : CALC;
         CALC:    if (w_last) w_next = DONE;
         DONE:    if (bus.out_ready) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Datapath: operand capture, iteration and result registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_work      <= '0;
         r_div_mag   <= '0;
         r_cnt       <= '0;
         r_q_neg     <= 1'b0;
         r_r_neg     <= 1'b0;
         r_quot      <= '0;
         r_rem       <= '0;
         r_dbz       <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_work    <= {{WIDTH{1'b0}}, w_a_mag};
                  r_div_mag <= w_b_mag;
                  r_q_neg   <= w_a_neg ^ w_b_neg;
                  r_r_neg   <= w_a_neg;
                  r_cnt     <= '0;
                  if (w_b_zero) begin
                     r_quot      <= '1;
                     r_rem       <= bus.dividend;
                     r_dbz       <= 1'b1;
                     r_out_valid <= 1'b1;
                  end else if (w_fast) begin
                     r_quot      <= '0;
                     r_rem       <= bus.dividend;
                     r_dbz       <= 1'b0;
                     r_out_valid <= 1'b1;
                  end
               end
            end
            CALC: begin
               if (w_last) begin
                  r_quot      <= w_q_fix;
                  r_rem       <= w_r_fix;
                  r_dbz       <= 1'b0;
                  r_out_valid <= 1'b1;
               end else begin
                  r_work <= w_step;
                  r_cnt  <= r_cnt + CW'(1);
               end
            end
            DONE: begin
               if (bus.out_ready) r_out_valid <= 1'b0;
            end
            default: r_out_valid <= 1'b0;
         endcase
      end
   end
endmodule

// File: tb/tb_div_seq_param.sv
// tb_div_seq_param: directed and randomized checks of div_seq_param.
// The bench uses a 32-bit instance and an 8-bit instance that share one clock.
module tb_div_seq_param;
   logic       clk;
   logic       rst;
   logic [1:0] dbg32;
   logic [1:0] dbg8;
   int         n_checks;
   int         n_errors;

   div_seq_param_if #(.WIDTH(32)) if32 ();
   div_seq_param_if #(.WIDTH(8))  if8 ();

   div_seq_param #(.WIDTH(32)) u_div32 (.clk(clk), .rst(rst), .bus(if32.slave), .o_dbg_state(dbg32));
   div_seq_param #(.WIDTH(8))  u_div8  (.clk(clk), .rst(rst), .bus(if8.slave),  .o_dbg_state(dbg8));

   // Clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Watchdog
   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference model: plain integer division on sign-extended operands.
   function automatic void ref_div(input int w, input logic [31:0] a_in, input logic [31:0] b_in,
                                   input bit s, output logic [31:0] q, output logic [31:0] r,
                                   output bit z);
      logic [31:0] m, a, b;
      longint sa, sb;
      m = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
      a = a_in & m;
      b = b_in & m;
      z = 1'b0;
      if (b == 0) begin
         q = m; r = a; z = 1'b1;
      end else if (s) begin
         sa = longint'(a); sb = longint'(b);
         if (a[w-1]) sa = sa - (longint'(1) << w);
         if (b[w-1]) sb = sb - (longint'(1) << w);
         q = 32'(sa / sb) & m;
         r = 32'(sa % sb) & m;
      end else begin
         q = a / b;
         r = a % b;
      end
   endfunction

   // Expected cycles from the accept edge until out_valid is seen
   function automatic int ref_lat(input int w, input logic [31:0] a_in, input logic [31:0] b_in,
                                  input bit s);
      logic [31:0] m, a, b;
      longint sa, sb;
      m = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
      a = a_in & m;
      b = b_in & m;
      if (b == 0) return 1;
      sa = longint'(a); sb = longint'(b);
      if (s && a[w-1]) sa = (longint'(1) << w) - sa;
      if (s && b[w-1]) sb = (longint'(1) << w) - sb;
`ifdef DIV_SEQ_FASTPATH_EN
      if (sb > sa) return 1;
`endif
      return w + 1;
   endfunction

   // Driver for the 32-bit instance. It performs one complete transaction.
   task automatic op32(input logic [31:0] a, input logic [31:0] b, input bit s,
                       output logic [31:0] q, output logic [31:0] r, output bit z,
                       output int lat, output bit busy_ok);
      int guard;
      q = '0; r = '0; z = 1'b0; lat = -1; busy_ok = 1'b1;
      @(negedge clk);
      if32.in_valid = 1'b1; if32.dividend = a; if32.divisor = b; if32.signed_op = s;
      if32.out_ready = 1'b0;
      guard = 0;
      while (!if32.in_ready && guard < 200) begin @(negedge clk); guard++; end
      if (guard >= 200) begin
         n_checks++; n_errors++;
         $display("FAIL accept32 timeout: in_ready never rose");
         if32.in_valid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      if32.in_valid = 1'b0; if32.dividend = $urandom; if32.divisor = $urandom;
      if32.signed_op = 1'($urandom_range(0, 1));
      lat = 0;
      while (lat < 200) begin
         @(negedge clk); lat++;
         if (if32.in_ready) busy_ok = 1'b0;
         if (if32.out_valid) break;
      end
      if (!if32.out_valid) begin
         n_checks++; n_errors++;
         $display("FAIL result32 timeout: out_valid never rose");
         lat = -1;
         return;
      end
      q = if32.quotient; r = if32.remainder; z = if32.div_by_zero;
      if32.out_ready = 1'b1;
      @(posedge clk); #1;
      if32.out_ready = 1'b0;
   endtask

   // Driver for the 8-bit instance
   task automatic op8(input logic [7:0] a, input logic [7:0] b, input bit s,
                      output logic [7:0] q, output logic [7:0] r, output bit z,
                      output int lat, output bit busy_ok);
      int guard;
      q = '0; r = '0; z = 1'b0; lat = -1; busy_ok = 1'b1;
      @(negedge clk);
      if8.in_valid = 1'b1; if8.dividend = a; if8.divisor = b; if8.signed_op = s;
      if8.out_ready = 1'b0;
      guard = 0;
      while (!if8.in_ready && guard < 200) begin @(negedge clk); guard++; end
      if (guard >= 200) begin
         n_checks++; n_errors++;
         $display("FAIL accept8 timeout: in_ready never rose");
         if8.in_valid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      if8.in_valid = 1'b0; if8.dividend = 8'($urandom); if8.divisor = 8'($urandom);
      lat = 0;
      while (lat < 200) begin
         @(negedge clk); lat++;
         if (if8.in_ready) busy_ok = 1'b0;
         if (if8.out_valid) break;
      end
      if (!if8.out_valid) begin
         n_checks++; n_errors++;
         $display("FAIL result8 timeout: out_valid never rose");
         lat = -1;
         return;
      end
      q = if8.quotient; r = if8.remainder; z = if8.div_by_zero;
      if8.out_ready = 1'b1;
      @(posedge clk); #1;
      if8.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({if32.out_valid, if32.quotient, if32.remainder, if32.div_by_zero, dbg32} !== {1'b0, 32'd0, 32'd0, 1'b0, 2'd0}) begin
         n_errors++;
         $display("FAIL reset32 got v=%b q=%h r=%h z=%b st=%0d want all zero", if32.out_valid, if32.quotient, if32.remainder, if32.div_by_zero, dbg32);
      end
      n_checks++;
      if ({if8.out_valid, if8.quotient, if8.remainder, if8.div_by_zero, dbg8} !== 19'd0) begin
         n_errors++;
         $display("FAIL reset8 got v=%b q=%h r=%h z=%b st=%0d want all zero", if8.out_valid, if8.quotient, if8.remainder, if8.div_by_zero, dbg8);
      end
      n_checks++;
      if ({if32.in_ready, if8.in_ready} !== 2'b00) begin
         n_errors++;
         $display("FAIL ready_in_reset got %b want 00", {if32.in_ready, if8.in_ready});
      end
      rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({if32.in_ready, if8.in_ready} !== 2'b11) begin
         n_errors++;
         $display("FAIL ready_after_reset got %b want 11", {if32.in_ready, if8.in_ready});
      end
   endtask

   // Runs one 32-bit op and compares it against the model
   task automatic check32(input string name, input logic [31:0] a, input logic [31:0] b, input bit s);
      logic [31:0] q, r, eq, er;
      bit z, ez, bok;
      int lat, el;
      op32(a, b, s, q, r, z, lat, bok);
      ref_div(32, a, b, s, eq, er, ez);
      el = ref_lat(32, a, b, s);
      n_checks++;
      if ({q, r, z} !== {eq, er, ez}) begin
         n_errors++;
         $display("FAIL %s got q=%h r=%h z=%0d want q=%h r=%h z=%0d", name, q, r, z, eq, er, ez);
      end
      n_checks++;
      if (lat !== el) begin
         n_errors++;
         $display("FAIL %s_latency got %0d want %0d", name, lat, el);
      end
      n_checks++;
      if (bok !== 1'b1) begin
         n_errors++;
         $display("FAIL %s_in_ready got high while busy want low", name);
      end
   endtask

   task automatic test_unsigned();
      check32("udiv_100_7", 32'd100, 32'd7, 1'b0);
      n_checks++;
      if (ref_lat(32, 32'd100, 32'd7, 1'b0) !== 33) begin
         n_errors++;
         $display("FAIL model_latency got %0d want 33", ref_lat(32, 32'd100, 32'd7, 1'b0));
      end
      check32("udiv_big", 32'hFFFF_FFFE, 32'd3, 1'b0);
   endtask

   task automatic test_signed();
      check32("sdiv_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1);
      check32("sdiv_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1);
      check32("sdiv_m7_m2", 32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1);
   endtask

   task automatic test_overflow();
      check32("sdiv_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
      check32("udiv_msb", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
   endtask

   task automatic test_div_zero();
      check32("dbz_5_0", 32'd5, 32'd0, 1'b0);
      check32("after_dbz_9_3", 32'd9, 32'd3, 1'b0);
      check32("dbz_signed", 32'hFFFF_FF00, 32'd0, 1'b1);
   endtask

   task automatic test_small_quotient();
      check32("small_3_100", 32'd3, 32'd100, 1'b0);
      check32("small_m3_100", 32'hFFFF_FFFD, 32'd100, 1'b1);
   endtask

   task automatic test_backpressure();
      logic [31:0] eq, er;
      bit ez, stable, ready_low;
      int guard;
      ref_div(32, 32'd123456, 32'd789, 1'b0, eq, er, ez);
      @(negedge clk);
      if32.in_valid = 1'b1; if32.dividend = 32'd123456; if32.divisor = 32'd789;
      if32.signed_op = 1'b0; if32.out_ready = 1'b0;
      guard = 0;
      while (!if32.in_ready && guard < 200) begin @(negedge clk); guard++; end
      @(posedge clk); #1;
      if32.dividend = 32'd50; if32.divisor = 32'd5;
      guard = 0;
      while (!if32.out_valid && guard < 200) begin @(negedge clk); guard++; end
      n_checks++;
      if (if32.out_valid !== 1'b1) begin
         n_errors++;
         $display("FAIL bp_result got out_valid=%b want 1", if32.out_valid);
      end
      stable = 1'b1; ready_low = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if ({if32.out_valid, if32.quotient, if32.remainder, if32.div_by_zero} !== {1'b1, eq, er, 1'b0}) stable = 1'b0;
         if (if32.in_ready !== 1'b0) ready_low = 1'b0;
      end
      n_checks++;
      if (stable !== 1'b1) begin
         n_errors++;
         $display("FAIL bp_stable got q=%h r=%h v=%b want q=%h r=%h v=1", if32.quotient, if32.remainder, if32.out_valid, eq, er);
      end
      n_checks++;
      if (ready_low !== 1'b1) begin
         n_errors++;
         $display("FAIL bp_in_ready got high during DONE want low");
      end
      if32.out_ready = 1'b1; if32.in_valid = 1'b0;
      @(posedge clk); #1;
      if32.out_ready = 1'b0;
      n_checks++;
      if (if32.out_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL bp_release got out_valid=%b want 0", if32.out_valid);
      end
      @(negedge clk);
      n_checks++;
      if ({if32.in_ready, dbg32} !== {1'b1, 2'd0}) begin
         n_errors++;
         $display("FAIL bp_ready_back got in_ready=%b st=%0d want 1 0", if32.in_ready, dbg32);
      end
   endtask

   task automatic test_reset_midop();
      int guard;
      @(negedge clk);
      if32.in_valid = 1'b1; if32.dividend = 32'd1000000; if32.divisor = 32'd3;
      if32.signed_op = 1'b0; if32.out_ready = 1'b1;
      guard = 0;
      while (!if32.in_ready && guard < 200) begin @(negedge clk); guard++; end
      @(posedge clk); #1;
      if32.in_valid = 1'b0;
      repeat (10) @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if ({if32.out_valid, if32.quotient, if32.remainder, dbg32} !== {1'b0, 32'd0, 32'd0, 2'd0}) begin
         n_errors++;
         $display("FAIL midop_reset got v=%b q=%h r=%h st=%0d want 0 0 0 0", if32.out_valid, if32.quotient, if32.remainder, dbg32);
      end
      @(negedge clk);
      rst = 1'b0;
      if32.out_ready = 1'b0;
      repeat (40) @(negedge clk);
      n_checks++;
      if (if32.out_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL midop_no_output got out_valid=%b want 0", if32.out_valid);
      end
      check32("after_reset_1000_10", 32'd1000, 32'd10, 1'b0);
   endtask

   task automatic test_random32();
      logic [31:0] a, b;
      bit s;
      for (int i = 0; i < 20; i++) begin
         a = $urandom;
         b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
         s = 1'($urandom_range(0, 1));
         check32("rand32", a, b, s);
      end
   endtask

   task automatic test_width8();
      logic [7:0] a, b, q, r;
      logic [31:0] eq, er;
      bit s, z, ez, bok;
      int lat;
      for (int i = 0; i < 60; i++) begin
         if (i == 0) begin a = 8'h80; b = 8'hFF; s = 1'b1; end
         else if (i == 1) begin a = 8'h80; b = 8'hFF; s = 1'b0; end
         else if (i == 2) begin a = 8'd77; b = 8'd0; s = 1'b1; end
         else begin
            a = 8'($urandom);
            b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            s = 1'($urandom_range(0, 1));
         end
         op8(a, b, s, q, r, z, lat, bok);
         ref_div(8, {24'd0, a}, {24'd0, b}, s, eq, er, ez);
         n_checks++;
         if ({q, r, z} !== {eq[7:0], er[7:0], ez}) begin
            n_errors++;
            $display("FAIL w8 a=%h b=%h s=%0d got q=%h r=%h z=%0d want q=%h r=%h z=%0d", a, b, s, q, r, z, eq[7:0], er[7:0], ez);
         end
         if (b != 0) begin
            n_checks++;
            if (8'(q * b + r) !== a) begin
               n_errors++;
               $display("FAIL w8_invariant a=%h b=%h got q*b+r=%h want %h", a, b, 8'(q * b + r), a);
            end
         end
         n_checks++;
         if (lat !== ref_lat(8, {24'd0, a}, {24'd0, b}, s) || bok !== 1'b1) begin
            n_errors++;
            $display("FAIL w8_latency a=%h b=%h got %0d busy_ok=%0d want %0d", a, b, lat, bok, ref_lat(8, {24'd0, a}, {24'd0, b}, s));
         end
      end
   endtask

   // Test sequence
   initial begin
      n_checks = 0; n_errors = 0;
      rst = 1'b1;
      if32.in_valid = 1'b0; if32.dividend = '0; if32.divisor = '0; if32.signed_op = 1'b0; if32.out_ready = 1'b0;
      if8.in_valid = 1'b0;  if8.dividend = '0;  if8.divisor = '0;  if8.signed_op = 1'b0;  if8.out_ready = 1'b0;
      test_reset();
      test_unsigned();
      test_signed();
      test_overflow();
      test_div_zero();
      test_small_quotient();
      test_backpressure();
      test_reset_midop();
      test_random32();
      test_width8();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
